// File: rtl/bram_read_streamer.sv
// Burst read sequencer for one BRAM port: issues sequential reads, absorbs the
// fixed read latency and returns the words as a valid/ready stream via a small FIFO.
module bram_read_streamer #(
  parameter int DATA_WIDTH   = 18,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
  input  logic [ADDR_WIDTH:0]   LENGTH,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [14:0]           ADDR,
  output logic                  EN,
  output logic                  REGCE,
  output logic [3:0]            WE,
  input  logic [DATA_WIDTH-1:0] DO,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  M_VALID,
  input  logic                  M_READY
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
      $error("bram_read_streamer: READ_LATENCY must be 1 or 2");
    end
    if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < READ_LATENCY + 1) begin : g_bad_depth
      $error("bram_read_streamer: FIFO_DEPTH must be a power of two >= READ_LATENCY+1");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_t;

  state_t                  r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH:0]     r_rem;
  logic [READ_LATENCY-1:0] r_vld_pipe;
  logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PW:0]             r_wptr, r_rptr;
  logic [PW:0]             w_count;
  logic [CW-1:0]           w_inflight;
  logic                    w_credit, w_en, w_push, w_pop, w_empty, w_full;

  assign w_count = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_push  = r_vld_pipe[READ_LATENCY-1];
  assign w_pop   = !w_empty && M_READY;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) w_inflight = w_inflight + CW'(r_vld_pipe[i]);
  end

  // Words in the latency pipe already own a FIFO slot, so the FIFO can never overflow.
  assign w_credit = (w_inflight + CW'(w_count)) < CW'(FIFO_DEPTH);

  always_comb begin
    w_state_nxt = r_state;
    w_en        = 1'b0;
    case (r_state)
      S_IDLE:   if (START) w_state_nxt = (LENGTH == '0) ? S_FINISH : S_ISSUE;
      S_ISSUE:  if (w_credit && r_rem != '0) begin
                  w_en = 1'b1;
                  if (r_rem == (ADDR_WIDTH+1)'(1)) w_state_nxt = S_DRAIN;
                end
      // Leave as soon as the last word is being accepted so DONE follows the final handshake.
      S_DRAIN:  if (w_inflight == '0 && (w_empty || (w_count == (PW+1)'(1) && w_pop)))
                  w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_vld_pipe <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && START) begin
        r_addr <= BASE_ADDR;
        r_rem  <= LENGTH;
      end else if (w_en) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
        r_rem  <= r_rem - (ADDR_WIDTH+1)'(1);
      end
      r_vld_pipe[0] <= w_en;
      for (int i = 1; i < READ_LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
      if (w_push) r_wptr <= r_wptr + (PW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= DO;
  end

  assert property (@(posedge CLK) disable iff (RST) !(w_push && w_full));

  assign BUSY    = (r_state != S_IDLE);
  assign DONE    = (r_state == S_FINISH);
  assign ADDR    = 15'(r_addr);
  assign EN      = w_en;
  assign REGCE   = BUSY;
  assign WE      = '0;
  assign M_VALID = !w_empty;
  assign M_DATA  = w_empty ? '0 : r_mem[r_rptr[PW-1:0]];
endmodule

// File: tb/tb_bram_read_streamer.sv
// Runs latency-1 and latency-2 streamers side by side against BRAM models;
// a burst-level reference model checks addresses, data order, credit, DONE timing.
module tb_bram_read_streamer;
  localparam int DW = 18, AW = 10, FD = 4, NW = 1 << AW;

  typedef struct {
    int base; int len; int mode; bit dbl;
    int exp_en; int exp_first; int exp_last; int lat1; int lat2;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start, rdy;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic          busy[2], done[2], en[2], regce[2], mvalid[2];
  logic [14:0]   addr[2];
  logic [3:0]    we[2];
  logic [DW-1:0] dout[2], mdata[2];
  logic [DW-1:0] mem [NW];

  int checks = 0, failures = 0, cyc = 0;
  int cur_base, cur_len;
  int en_cnt[2], hs_cnt[2], done_cnt[2], first_vld[2], last_hs[2], start_cyc[2], done_rel[2];
  int first_data[2], last_data[2];
  bit prev_stall[2];
  logic [DW-1:0] prev_data[2];
  vec_t vecs[6];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] r_do1;
    bram_read_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(g + 1), .FIFO_DEPTH(FD)) u_dut (
      .CLK(clk), .RST(rst), .START(start), .BASE_ADDR(base), .LENGTH(len),
      .BUSY(busy[g]), .DONE(done[g]), .ADDR(addr[g]), .EN(en[g]), .REGCE(regce[g]),
      .WE(we[g]), .DO(dout[g]), .M_DATA(mdata[g]), .M_VALID(mvalid[g]), .M_READY(rdy));
    always @(posedge clk) if (en[g]) r_do1 <= mem[addr[g][AW-1:0]];
    if (g == 0) begin : g_l1
      assign dout[g] = r_do1;
    end else begin : g_l2
      logic [DW-1:0] r_do2;
      always @(posedge clk) if (regce[g]) r_do2 <= r_do1;
      assign dout[g] = r_do2;
    end
  end

  task automatic chk(input string name, input int inst, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[lat%0d] got=%0d expected=%0d (cycle %0d)", name, inst + 1, act, exp, cyc);
    end
  endtask

  // Expected k-th read address / k-th word of a burst follow directly from base+k.
  task automatic monitor();
    for (int g = 0; g < 2; g++) begin
      if (rst) prev_stall[g] = 1'b0;
      else begin
        if (start && !busy[g]) begin
          en_cnt[g] = 0; hs_cnt[g] = 0; done_cnt[g] = 0; first_vld[g] = -1;
          last_hs[g] = -1; start_cyc[g] = cyc; first_data[g] = 0; last_data[g] = 0; done_rel[g] = -1;
        end
        if (en[g]) begin
          chk("addr", g, addr[g], (cur_base + en_cnt[g]) % NW);
          chk("overissue", g, en_cnt[g] < cur_len, 1);
          chk("credit", g, (en_cnt[g] - hs_cnt[g]) < FD, 1);
          en_cnt[g]++;
        end
        if (prev_stall[g]) begin
          chk("hold_valid", g, mvalid[g], 1);
          chk("hold_data", g, mdata[g], prev_data[g]);
        end
        if (mvalid[g] && first_vld[g] < 0) begin
          first_vld[g] = cyc - start_cyc[g];
          first_data[g] = mdata[g];
        end
        if (mvalid[g] && rdy) begin
          chk("data", g, mdata[g], mem[(cur_base + hs_cnt[g]) % NW]);
          last_data[g] = mdata[g]; last_hs[g] = cyc; hs_cnt[g]++;
        end
        if (done[g]) begin
          chk("done_words", g, hs_cnt[g], cur_len);
          chk("done_cycle", g, cyc, (cur_len == 0) ? start_cyc[g] + 1 : last_hs[g] + 1);
          done_rel[g] = cyc - start_cyc[g];
          done_cnt[g]++;
        end
        prev_stall[g] = mvalid[g] && !rdy;
        prev_data[g]  = mdata[g];
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs();
    for (int g = 0; g < 2; g++) begin
      chk("rst_busy", g, busy[g], 0);   chk("rst_done", g, done[g], 0);
      chk("rst_addr", g, addr[g], 0);   chk("rst_en", g, en[g], 0);
      chk("rst_regce", g, regce[g], 0); chk("rst_we", g, we[g], 0);
      chk("rst_mvalid", g, mvalid[g], 0); chk("rst_mdata", g, mdata[g], 0);
    end
  endtask

  // mode 0: ready held high, 1: ready low for 20 cycles then high, 2: random ready
  task automatic run_vec(input vec_t v);
    int n;
    cur_base = v.base; cur_len = v.len;
    base = AW'(v.base); len = (AW+1)'(v.len); start = 1'b1;
    rdy = (v.mode == 0);
    step();
    start = 1'b0;
    if (v.dbl) begin
      start = 1'b1; base = AW'(v.base + 7); len = (AW+1)'(5);
    end
    n = 0;
    while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && n < 4000) begin
      case (v.mode)
        0: rdy = 1'b1;
        1: rdy = (n >= 20);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (v.mode == 1 && n == 20) begin
        chk("stall_en", 0, en_cnt[0], FD);
        chk("stall_en", 1, en_cnt[1], FD);
      end
      step();
      start = 1'b0;
      n++;
    end
    chk("burst_timeout", 0, n < 4000, 1);
    step(); step();
    for (int g = 0; g < 2; g++) begin
      chk("en_count", g, en_cnt[g], v.exp_en);
      chk("words", g, hs_cnt[g], v.exp_en);
      chk("done_pulses", g, done_cnt[g], 1);
      chk("first_data", g, first_data[g], v.exp_first);
      chk("last_data", g, last_data[g], v.exp_last);
      chk("first_valid_lat", g, first_vld[g], g ? v.lat2 : v.lat1);
      chk("idle_busy", g, busy[g], 0);
      chk("idle_mvalid", g, mvalid[g], 0);
      if (v.mode == 0 && v.len > 0)
        chk("throughput", g, done_rel[g], (g ? v.lat2 : v.lat1) + v.len);
    end
  endtask

  initial begin
    int n, b, l;
    vec_t rv;
    for (int k = 0; k < NW; k++) mem[k] = DW'(k + 'h100);
    for (int g = 0; g < 2; g++) begin
      en_cnt[g] = 0; hs_cnt[g] = 0; done_cnt[g] = 0; first_vld[g] = -1; last_hs[g] = -1;
      start_cyc[g] = 0; done_rel[g] = -1; first_data[g] = 0; last_data[g] = 0;
      prev_stall[g] = 1'b0; prev_data[g] = '0;
    end
    vecs[0] = '{5,    8,    0, 0, 8,    'h105, 'h10C, 3, 4};
    vecs[1] = '{1022, 4,    0, 0, 4,    'h4FE, 'h101, 3, 4};
    vecs[2] = '{0,    16,   1, 0, 16,   'h100, 'h10F, 3, 4};
    vecs[3] = '{10,   0,    0, 1, 0,    0,     0,     -1, -1};
    vecs[4] = '{1000, 30,   2, 0, 30,   'h4E8, 'h105, 3, 4};
    vecs[5] = '{3,    1024, 0, 0, 1024, 'h103, 'h102, 3, 4};

    rst = 1'b1; start = 1'b0; rdy = 1'b0; base = '0; len = '0;
    step(); step();
    check_reset_outputs();
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset in the middle of a burst after three words have been accepted.
    cur_base = 50; cur_len = 20; base = AW'(50); len = (AW+1)'(20); start = 1'b1; rdy = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (hs_cnt[0] < 3 && n < 100) begin step(); n++; end
    chk("midrst_timeout", 0, n < 100, 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    step(); step();
    chk("midrst_no_done", 0, done_cnt[0], 0);
    chk("midrst_no_done", 1, done_cnt[1], 0);
    rst = 1'b0;
    step();
    rv = '{50, 20, 0, 0, 20, 'h132, 'h145, 3, 4};
    run_vec(rv);

    for (int i = 0; i < 6; i++) begin
      b = int'($urandom_range(0, NW - 1));
      l = int'($urandom_range(0, 40));
      rv = '{b, l, 2, 0, l, (l > 0) ? int'(mem[b]) : 0,
             (l > 0) ? int'(mem[(b + l - 1) % NW]) : 0,
             (l > 0) ? 3 : -1, (l > 0) ? 4 : -1};
      run_vec(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram_read_streamer.md
Name: bram_read_streamer

Overview:
Read-side sequencer placed directly on one port of the true-dual-port BRAM wrapper. On a start command it issues a burst of sequential BRAM reads and absorbs the fixed BRAM read latency (1 cycle, or 2 with the optional output register). It returns the data as a valid/ready stream with full backpressure support. Read issue is credit-limited against a small internal FIFO, so no read data is ever dropped.

Parameters:
DATA_WIDTH, 18, BRAM read width; equals READ_WIDTH of the attached port (1-36).
ADDR_WIDTH, 10, number of significant address bits. Bits 14:ADDR_WIDTH of ADDR are driven 0.
READ_LATENCY, 1, BRAM read latency. 1 when DO*_REG=0, 2 when DO*_REG=1. Other values are illegal (elaboration error).
FIFO_DEPTH, 4, output FIFO entries. Power of two, at least READ_LATENCY+1.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
START  in  1  single-cycle command strobe; sampled only in IDLE
BASE_ADDR  in  ADDR_WIDTH  first read address; sampled with START
LENGTH  in  ADDR_WIDTH+1  number of words to read (0 to 2^ADDR_WIDTH); sampled with START
BUSY  out  1  high from the cycle after an accepted START until the cycle DONE pulses (inclusive)
DONE  out  1  single-cycle pulse at burst end
ADDR  out  15  to BRAM ADDRA/ADDRB
EN  out  1  to BRAM ENA/ENB; high only in read-issue cycles
REGCE  out  1  to BRAM REGCEA/REGCEB; high whenever BUSY (don't-care for READ_LATENCY=1)
WE  out  4  to BRAM WEA/WEB; constant 0
DO  in  DATA_WIDTH  from BRAM DOA/DOB
M_DATA  out  DATA_WIDTH  stream data = FIFO head
M_VALID  out  1  FIFO non-empty
M_READY  in  1  downstream accept

Behaviour:
- Reset values: BUSY=0, DONE=0, ADDR=0, EN=0, REGCE=0, WE=0, M_VALID=0, M_DATA=0.
- Reset clears the FSM, counters, the latency pipeline and the FIFO. Asserting RST mid-burst discards in-flight and buffered words, and no DONE is produced. The BRAM's own RST is not driven by this block.
- FSM states:
  - IDLE: on START, load addr_q=BASE_ADDR and remaining=LENGTH.
    - LENGTH=0: go to FINISH (DONE pulses one cycle after START; no reads issued).
    - Otherwise: go to ISSUE.
  - ISSUE: each cycle with remaining>0 and credit available:
    - EN=1, ADDR=addr_q.
    - addr_q increments modulo 2^ADDR_WIDTH (wraps 2^ADDR_WIDTH-1 -> 0).
    - remaining decrements.
    - When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until in_flight=0 and the FIFO is empty (last word accepted), then go to FINISH.
  - FINISH: DONE=1 for one cycle, go to IDLE. BUSY is high in FINISH and low in IDLE.
- START while not in IDLE is ignored.
- Latency pipeline: a READ_LATENCY-deep shift register of valid bits, shifted every cycle and fed by EN. Its output pushes DO into the FIFO. A read issued in cycle t is written to the FIFO at the end of cycle t+READ_LATENCY, so M_VALID can rise in cycle t+READ_LATENCY+1 at the earliest.
- Credit: issue is allowed iff in_flight + fifo_count < FIFO_DEPTH. in_flight is the popcount of the pipeline. The FIFO therefore never overflows; a push with the FIFO full is an assertion failure.
- Throughput: with M_READY held high, EN is asserted every cycle and there is one word per cycle on M_DATA. Simultaneous push and pop leaves the count unchanged.
- The stream is AXI-style: once M_VALID is high, M_VALID and M_DATA hold until M_READY.
- FIFO pointers are log2(FIFO_DEPTH) bits with an extra wrap bit for full/empty detection.

Test Plan:
- BRAM preloaded with mem[k]=k+0x100, READ_LATENCY=1, BASE_ADDR=5, LENGTH=8, M_READY=1 -> EN high 8 consecutive cycles, ADDR 5..12; M_DATA 0x105..0x10C in order, 1 word/cycle; DONE pulses once, one cycle after the last handshake.
- READ_LATENCY=2 (DOB_REG=1), same burst -> identical data sequence; first M_VALID is one cycle later than the latency-1 case.
- M_READY=0 for the first 20 cycles, LENGTH=16, FIFO_DEPTH=4 -> exactly 4 EN pulses, then EN stays low, M_VALID stays high and M_DATA is stable. After M_READY=1, all 16 words arrive in order with none lost or duplicated.
- BASE_ADDR=1022, LENGTH=4, ADDR_WIDTH=10 -> ADDR sequence 1022, 1023, 0, 1.
- LENGTH=0 -> no EN, no M_VALID; DONE one cycle after START. A second START issued while BUSY is ignored.
- RST asserted mid-burst after 3 words are accepted -> all outputs return to reset values asynchronously with no DONE. A fresh START then runs the full burst correctly.
